vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Pixel-timing generator for the 640x480@60 Hz VGA path. Runs on the 25.175 MHz pixel clock and produces the raster counters, blanking flag, line/frame strobes and a frame counter that the renderer consumes. It also produces sync outputs delayed by a configurable number of cycles so HSYNC/VSYNC stay aligned with the renderer's registered RGB at the TinyVGA PMOD.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (cycles)
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, active level of both syncs (0 = active-low)
- PIPE_DELAY, 1, cycles of delay on hsync/vsync/display_on_d (0..4)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset; synchronous, active-low
- hpos  out  10  current pixel column
- vpos  out  10  current line
- display_on  out  1  high when hpos < H_DISPLAY and vpos < V_DISPLAY
- line_start  out  1  one-cycle pulse when hpos == 0
- frame_start  out  1  one-cycle pulse when hpos == 0 and vpos == 0
- frame_count  out  8  frame counter
- hsync  out  1  horizontal sync, delayed by PIPE_DELAY
- vsync  out  1  vertical sync, delayed by PIPE_DELAY
- display_on_d  out  1  display_on delayed by PIPE_DELAY

## Operation
- H_TOTAL = sum of the H_* parameters = 800. V_TOTAL = sum of the V_* parameters = 525. Both must be ≤ 1024; elaboration fails otherwise.
- hpos advances by 1 every cycle. At H_TOTAL-1 it wraps to 0, and vpos advances.
- vpos wraps from V_TOTAL-1 to 0.
- display_on, line_start, frame_start and the undelayed syncs are registered. They are decoded from next-state counters, so they are valid in the same cycle as the hpos/vpos they describe.
- Raw hsync is active for hpos in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] = [656, 751]. Otherwise it sits at the inactive level (!SYNC_POL).
- Raw vsync is active for vpos in [490, 491] across whole lines.
- frame_count increments in the same edge that asserts frame_start. It wraps 255 -> 0.
- hsync, vsync and display_on_d pass through a PIPE_DELAY-stage shift register. With PIPE_DELAY=0 they equal the raw signals.
- No handshake; the block is free-running. Downstream logic samples it every cycle.

## Timing
Reset values (while rst_n low, and on the edge that samples it low):
- hpos = H_TOTAL-1 = 799, vpos = V_TOTAL-1 = 524
- display_on = 0, line_start = 0, frame_start = 0, frame_count = 0
- All delay stages filled with inactive sync and display_on_d = 0, so hsync = vsync = 1 and display_on_d = 0.

First edge with rst_n high:
- hpos = 0, vpos = 0, display_on = 1, line_start = 1, frame_start = 1, frame_count = 1.

Cycle counts:
- line_start period is 800 cycles. frame_start period is 420000 cycles.
- hsync is active for exactly 96 consecutive cycles per line. vsync is active for exactly 1600 consecutive cycles per frame.
- Delayed outputs lag the raw values by exactly PIPE_DELAY edges.

Boundary conditions:
- Reset mid-frame takes effect on the next edge: counters jump to (799, 524) and the strobes clear.
- frame_count and the delay pipe are also cleared.
- There is no glitch pulse on the first line after release.
- At (799, 524) -> (0, 0), line_start and frame_start assert together.

## Structure
- Package vga_timing_pkg holds:
  - the 640x480 constants (H_DISPLAY..V_BACK), H_TOTAL and V_TOTAL
  - DISPLAY_WIDTH and DISPLAY_HEIGHT, shared with the renderer and the bounce logic.
- Sub-module sync_delay_line (parameter DEPTH, WIDTH, RESET_VALUE) implements the 3-bit {hsync, vsync, display_on} delay. It is a pass-through when DEPTH = 0.
- Counters and decode live in vga_timing_gen itself.

## Test plan
- Reset: hold rst_n low for 5 cycles, with defaults.
  -> hpos = 799, vpos = 524, display_on = 0, frame_count = 0, hsync = vsync = 1.
- Release: first edge after rst_n high.
  -> hpos = 0, vpos = 0, frame_start = 1, line_start = 1, frame_count = 1.
  -> The next cycle, both strobes are 0.
- Line timing, PIPE_DELAY = 1:
  -> raw hsync is low for hpos 656..751; hsync output is low while hpos is 657..752.
  -> display_on falls when hpos = 640.
  -> line_start pulses every 800 cycles.
- Frame timing:
  -> vsync is low only while vpos is 490/491 (PIPE_DELAY = 1, lagging 1 cycle).
  -> display_on = 0 for all vpos ≥ 480.
  -> frame_start pulses are spaced 420000 cycles apart.
  -> frame_count wraps 255 -> 0 after 256 frames.
- Mid-frame reset at vpos = 300, hpos = 123.
  -> The next edge gives reset values, including hsync = 1 and display_on_d = 0.
  -> Release reproduces the release scenario exactly.
- PIPE_DELAY = 0 and PIPE_DELAY = 4 builds.
  -> hsync/vsync/display_on_d equal the raw signals delayed by exactly 0 and 4 cycles respectively, every cycle over 2 frames.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants shared by the timing generator, renderer and bounce logic
package vga_timing_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DISPLAY_WIDTH = H_DISPLAY;
  localparam int DISPLAY_HEIGHT = V_DISPLAY;
  typedef logic [9:0] coord_t;
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle; master = generator, slave = renderer/PMOD side
//   hpos/vpos      raster position
//   display_on     visible-area flag
//   line_start     pulse at hpos 0
//   frame_start    pulse at (0,0)
//   frame_count    8-bit frame counter
//   hsync/vsync    delayed syncs
//   display_on_d   display_on delayed like the syncs
interface vga_timing_gen_if;
  import vga_timing_pkg::*;
  coord_t hpos;
  coord_t vpos;
  logic display_on;
  logic line_start;
  logic frame_start;
  logic [7:0] frame_count;
  logic hsync;
  logic vsync;
  logic display_on_d;
  modport master(output hpos, vpos, display_on, line_start, frame_start, frame_count, hsync, vsync, display_on_d);
  modport slave(input hpos, vpos, display_on, line_start, frame_start, frame_count, hsync, vsync, display_on_d);
endinterface

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage shift register with reset fill value; wire when DEPTH = 0
//   clk, rst_n  clock, sync active-low reset
//   d           input word
//   q           d delayed by DEPTH edges
module sync_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q = d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VALUE;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end
    assign q = stage[DEPTH-1];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster counters, decode strobes, frame counter and delayed syncs
//   clk    pixel clock
//   rst_n  sync active-low reset
//   vga    timing bundle (master)
module vga_timing_gen #(
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DELAY = 1
) (
  input logic clk,
  input logic rst_n,
  vga_timing_gen_if.master vga
);
  import vga_timing_pkg::*;
  localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  if (HT > 1024 || VT > 1024 || PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_params
    $error("vga_timing_gen: totals must be <= 1024 and PIPE_DELAY in 0..4");
  end
  localparam coord_t H_LAST = coord_t'(HT - 1);
  localparam coord_t V_LAST = coord_t'(VT - 1);
  localparam coord_t H_VIS = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_ON = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_OFF = coord_t'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam coord_t VS_ON = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_OFF = coord_t'(V_DISPLAY + V_FRONT + V_SYNC);
  coord_t h, v, h_nx, v_nx;
  logic display_on, line_start, frame_start, hs_raw, vs_raw, f_nx;
  logic [7:0] frame_count;
  logic [2:0] dly_q;
  always_comb begin
    h_nx = (h == H_LAST) ? '0 : h + 1'b1;
    v_nx = (h != H_LAST) ? v : (v == V_LAST) ? '0 : v + 1'b1;
    f_nx = (h_nx == '0) && (v_nx == '0);
  end
  // Every flag is decoded from the next-state counters so it lines up with the hpos/vpos registered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= H_LAST;
      v <= V_LAST;
      display_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
      hs_raw <= !SYNC_POL;
      vs_raw <= !SYNC_POL;
    end else begin
      h <= h_nx;
      v <= v_nx;
      display_on <= (h_nx < H_VIS) && (v_nx < V_VIS);
      line_start <= h_nx == '0;
      frame_start <= f_nx;
      frame_count <= frame_count + {7'd0, f_nx};
      hs_raw <= (h_nx >= HS_ON && h_nx < HS_OFF) ? SYNC_POL : !SYNC_POL;
      vs_raw <= (v_nx >= VS_ON && v_nx < VS_OFF) ? SYNC_POL : !SYNC_POL;
    end
  end
  sync_delay_line #(
    .DEPTH(PIPE_DELAY),
    .WIDTH(3),
    .RESET_VALUE({!SYNC_POL, !SYNC_POL, 1'b0})
  ) u_sync_delay (
    .clk(clk),
    .rst_n(rst_n),
    .d({hs_raw, vs_raw, display_on}),
    .q(dly_q)
  );
  assign vga.hpos = h;
  assign vga.vpos = v;
  assign vga.display_on = display_on;
  assign vga.line_start = line_start;
  assign vga.frame_start = frame_start;
  assign vga.frame_count = frame_count;
  assign vga.hsync = dly_q[2];
  assign vga.vsync = dly_q[1];
  assign vga.display_on_d = dly_q[0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks default and reduced-raster builds (PIPE_DELAY 0/1/4) against an arithmetic raster model
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int t = -1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  vga_timing_gen_if if_def();
  vga_timing_gen_if if_s0();
  vga_timing_gen_if if_s1();
  vga_timing_gen_if if_s4();
  vga_timing_gen #(.PIPE_DELAY(1)) dut_def (.clk(clk), .rst_n(rst_n), .vga(if_def.master));
  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(0)) dut_s0 (.clk(clk), .rst_n(rst_n), .vga(if_s0.master));
  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(1)) dut_s1 (.clk(clk), .rst_n(rst_n), .vga(if_s1.master));
  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIPE_DELAY(4)) dut_s4 (.clk(clk), .rst_n(rst_n), .vga(if_s4.master));
  // Observed word: {hpos, vpos, display_on, line_start, frame_start, frame_count, hsync, vsync, display_on_d}
  logic [33:0] acts [4];
  assign acts[0] = {if_def.hpos, if_def.vpos, if_def.display_on, if_def.line_start, if_def.frame_start, if_def.frame_count, if_def.hsync, if_def.vsync, if_def.display_on_d};
  assign acts[1] = {if_s0.hpos, if_s0.vpos, if_s0.display_on, if_s0.line_start, if_s0.frame_start, if_s0.frame_count, if_s0.hsync, if_s0.vsync, if_s0.display_on_d};
  assign acts[2] = {if_s1.hpos, if_s1.vpos, if_s1.display_on, if_s1.line_start, if_s1.frame_start, if_s1.frame_count, if_s1.hsync, if_s1.vsync, if_s1.display_on_d};
  assign acts[3] = {if_s4.hpos, if_s4.vpos, if_s4.display_on, if_s4.line_start, if_s4.frame_start, if_s4.frame_count, if_s4.hsync, if_s4.vsync, if_s4.display_on_d};
  string nm [4] = '{"def", "s0", "s1", "s4"};
  bit sm [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  int dl [4] = '{1, 0, 1, 4};
  // t counts edges since release; -1 means the last edge sampled reset.
  always @(posedge clk) t <= rst_n ? t + 1 : -1;
  function automatic logic [2:0] raw(int tt, bit s);
    int hd, hf, hs, ht, vd, vf, vs, vt, h, v;
    hd = s ? 8 : 640; hf = s ? 2 : 16; hs = s ? 3 : 96; ht = s ? 15 : 800;
    vd = s ? 6 : 480; vf = s ? 1 : 10; vs = 2; vt = s ? 10 : 525;
    if (tt < 0) return 3'b110;
    h = tt % ht;
    v = (tt / ht) % vt;
    return {!(h >= hd + hf && h < hd + hf + hs), !(v >= vd + vf && v < vd + vf + vs), h < hd && v < vd};
  endfunction
  function automatic logic [33:0] model(int tt, bit s, int d);
    int ht, vt, h, v;
    logic [2:0] r;
    ht = s ? 15 : 800;
    vt = s ? 10 : 525;
    if (tt < 0) return {10'(ht - 1), 10'(vt - 1), 3'b000, 8'd0, 3'b110};
    h = tt % ht;
    v = (tt / ht) % vt;
    r = raw(tt, s);
    return {10'(h), 10'(v), r[0], h == 0, h == 0 && v == 0, 8'((tt / (ht * vt) + 1) % 256), raw(tt - d, s)};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset(int n);
    logic [33:0] w;
    rst_n = 1'b0;
    repeat (n) begin
      step();
      w = {10'd799, 10'd524, 3'b000, 8'd0, 3'b110};
      total++;
      if (acts[0] !== w) begin
        bad++;
        $display("FAIL reset_def t=%0d got=%h want=%h", t, acts[0], w);
      end
      for (int k = 1; k < 4; k++) begin
        w = model(t, sm[k], dl[k]);
        total++;
        if (acts[k] !== w) begin
          bad++;
          $display("FAIL reset_%s got=%h want=%h", nm[k], acts[k], w);
        end
      end
    end
  endtask
  task automatic test_release();
    logic [33:0] w;
    rst_n = 1'b1;
    step();
    w = {10'd0, 10'd0, 3'b111, 8'd1, 3'b110};
    total++;
    if (acts[0] !== w) begin
      bad++;
      $display("FAIL release_def got=%h want=%h", acts[0], w);
    end
    for (int k = 1; k < 4; k++) begin
      w = model(t, sm[k], dl[k]);
      total++;
      if (acts[k] !== w) begin
        bad++;
        $display("FAIL release_%s got=%h want=%h", nm[k], acts[k], w);
      end
    end
    step();
    total++;
    if (acts[0][12:11] !== 2'b00) begin
      bad++;
      $display("FAIL release_strobes_clear got=%b want=00", acts[0][12:11]);
    end
  endtask
  task automatic run_model(int n, string tag);
    logic [33:0] w;
    int last_ls = -1, last_fs = -1, hrun = 0, vrun = 0, prev_fc = -1;
    bit wrap_seen = 0;
    repeat (n) begin
      step();
      for (int k = 0; k < 4; k++) begin
        w = model(t, sm[k], dl[k]);
        total++;
        if (acts[k] !== w) begin
          bad++;
          $display("FAIL %s_%s t=%0d got=%h want=%h", tag, nm[k], t, acts[k], w);
        end
      end
      if (if_def.line_start) begin
        if (last_ls >= 0) begin
          total++;
          if (t - last_ls !== 800) begin
            bad++;
            $display("FAIL line_period got=%0d want=800", t - last_ls);
          end
        end
        last_ls = t;
      end
      if (!if_def.hsync) hrun++;
      else begin
        if (hrun > 0) begin
          total++;
          if (hrun !== 96) begin
            bad++;
            $display("FAIL hsync_width got=%0d want=96", hrun);
          end
        end
        hrun = 0;
      end
      if (!if_s1.vsync) vrun++;
      else begin
        if (vrun > 0) begin
          total++;
          if (vrun !== 30) begin
            bad++;
            $display("FAIL vsync_width got=%0d want=30", vrun);
          end
        end
        vrun = 0;
      end
      if (if_s1.frame_start) begin
        if (last_fs >= 0) begin
          total++;
          if (t - last_fs !== 150) begin
            bad++;
            $display("FAIL frame_period got=%0d want=150", t - last_fs);
          end
        end
        last_fs = t;
        if (if_s1.frame_count == 8'd0 && prev_fc == 255) wrap_seen = 1'b1;
        prev_fc = int'(if_s1.frame_count);
      end
    end
    if (n > 256 * 150) begin
      total++;
      if (!wrap_seen) begin
        bad++;
        $display("FAIL frame_count_wrap got=no_wrap want=255->0");
      end
    end
  endtask
  task automatic test_line_timing();
    run_model(3 * 800, "line");
  endtask
  task automatic test_frame_timing();
    run_model(258 * 150, "frame");
  endtask
  task automatic test_mid_reset();
    run_model(int'($urandom_range(0, 2000)), "pre_reset");
    for (int i = 0; i < 800 && if_def.hpos !== 10'd123; i++) step();
    total++;
    if (if_def.hpos !== 10'd123) begin
      bad++;
      $display("FAIL mid_reset_reach got=%0d want=123", if_def.hpos);
    end
    test_reset(int'($urandom_range(1, 3)));
    test_release();
    run_model(int'($urandom_range(200, 600)), "post_reset");
  endtask
  initial begin
    test_reset(5);
    test_release();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
